// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: HD44780 init then endless buffer refresh; char_addr runs one fetch ahead for a sync-read buffer
module lcd_frame_sequencer #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int CLEAR_CYCLES   = 82000,
    parameter int REFRESH_CYCLES = 50000000,
    parameter int NUM_LINES      = 2,
    parameter int CHARS_PER_LINE = 16,
    parameter int CNT_W          = 26,
    localparam int TOTAL = NUM_LINES * CHARS_PER_LINE,
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          refresh_req,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_rs,
    output logic [7:0]    cmd_data,
    output logic [AW-1:0] char_addr,
    input  logic [7:0]    char_data,
    output logic          init_done,
    output logic          frame_done
);
    typedef enum logic [3:0] {
        IDLE, POWERUP_WAIT, FUNCTION_SET, ENTRY_MODE_SET, DISPLAY_ON_OFF,
        CLEAR_DISPLAY, CLEAR_WAIT, SET_DDRAM, FETCH, WRITE_CHAR, REFRESH_WAIT
    } state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [1:0] line;
    logic [5:0] col;
    logic xfer;
    assign xfer = cmd_valid && cmd_ready;
    function automatic logic [7:0] ddram(input logic [1:0] l);
        return 8'h80 | (l[0] ? 8'h40 : 8'h00) | (l[1] ? 8'h14 : 8'h00);
    endfunction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            line       <= '0;
            col        <= '0;
            cmd_valid  <= 1'b0;
            cmd_rs     <= 1'b0;
            cmd_data   <= '0;
            char_addr  <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    if (init_done) begin
                        state     <= SET_DDRAM;
                        cmd_valid <= 1'b1;
                        cmd_rs    <= 1'b0;
                        cmd_data  <= ddram(2'd0);
                    end else begin
                        state <= POWERUP_WAIT;
                        cnt   <= CNT_W'(POWERUP_CYCLES - 1);
                    end
                end
                POWERUP_WAIT: if (cnt == '0) begin
                    state     <= FUNCTION_SET;
                    cmd_valid <= 1'b1;
                    cmd_rs    <= 1'b0;
                    cmd_data  <= (NUM_LINES == 1) ? 8'h30 : 8'h38;
                end else cnt <= cnt - 1'b1;
                FUNCTION_SET: if (xfer) begin
                    state    <= ENTRY_MODE_SET;
                    cmd_data <= 8'h06;
                end
                ENTRY_MODE_SET: if (xfer) begin
                    state    <= DISPLAY_ON_OFF;
                    cmd_data <= 8'h0C;
                end
                DISPLAY_ON_OFF: if (xfer) begin
                    state    <= CLEAR_DISPLAY;
                    cmd_data <= 8'h01;
                end
                CLEAR_DISPLAY: if (xfer) begin
                    state     <= CLEAR_WAIT;
                    cmd_valid <= 1'b0;
                    cnt       <= CNT_W'(CLEAR_CYCLES - 1);
                end
                CLEAR_WAIT: if (cnt == '0) begin
                    state     <= SET_DDRAM;
                    init_done <= 1'b1;
                    cmd_valid <= 1'b1;
                    cmd_rs    <= 1'b0;
                    cmd_data  <= ddram(line);
                end else cnt <= cnt - 1'b1;
                SET_DDRAM: if (xfer) begin
                    state     <= FETCH;
                    cmd_valid <= 1'b0;
                    col       <= '0;
                end
                FETCH: begin
                    state     <= WRITE_CHAR;
                    cmd_valid <= 1'b1;
                    cmd_rs    <= 1'b1;
                    cmd_data  <= char_data;
                    char_addr <= (char_addr == AW'(TOTAL - 1)) ? '0 : char_addr + 1'b1;
                end
                WRITE_CHAR: if (xfer) begin
                    if (col != 6'(CHARS_PER_LINE - 1)) begin
                        state     <= FETCH;
                        cmd_valid <= 1'b0;
                        col       <= col + 1'b1;
                    end else if (line != 2'(NUM_LINES - 1)) begin
                        state    <= SET_DDRAM;
                        line     <= line + 1'b1;
                        col      <= '0;
                        cmd_rs   <= 1'b0;
                        cmd_data <= ddram(line + 1'b1);
                    end else begin
                        state      <= REFRESH_WAIT;
                        cmd_valid  <= 1'b0;
                        line       <= '0;
                        col        <= '0;
                        frame_done <= 1'b1;
                        cnt        <= CNT_W'(REFRESH_CYCLES - 1);
                    end
                end
                REFRESH_WAIT: if (!enable) state <= IDLE;
                else if (refresh_req || cnt == '0) begin
                    state     <= SET_DDRAM;
                    cmd_valid <= 1'b1;
                    cmd_rs    <= 1'b0;
                    cmd_data  <= ddram(2'd0);
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: scoreboard bench driving a 2x4 and a 4x20 sequencer against a frame-level model
module tb_lcd_frame_sequencer;
    localparam int PA = 10, CA = 5, RA = 20, LA = 2, WA = 4;
    localparam int PB = 3, CB = 2, RB = 5, LB = 4, WB = 20;
    localparam int AWA = 3, AWB = 7;
    typedef struct { logic rs; logic [7:0] data; int t; } item_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int ncyc = 0;
    int compared = 0, mismatched = 0;
    logic reset_a = 1'b1, enable_a = 1'b0, refresh_a = 1'b0, ready_a = 1'b1;
    logic valid_a, rs_a, init_a, fd_a;
    logic [7:0] data_a, cdata_a;
    logic [AWA-1:0] addr_a;
    logic [7:0] mem_a [LA*WA];
    logic reset_b = 1'b1, enable_b = 1'b0, refresh_b = 1'b0, ready_b = 1'b1;
    logic valid_b, rs_b, init_b, fd_b;
    logic [7:0] data_b, cdata_b;
    logic [AWB-1:0] addr_b;
    logic [7:0] mem_b [LB*WB];
    item_t qa[$], qb[$];
    int fqa[$], fqb[$];
    int mode_a = 0, stall = 0;
    logic done_b = 1'b0;
    int max_b = 0, prev_addr_b = 0;
    logic wrap_b = 1'b0;
    lcd_frame_sequencer #(.POWERUP_CYCLES(PA), .CLEAR_CYCLES(CA), .REFRESH_CYCLES(RA),
        .NUM_LINES(LA), .CHARS_PER_LINE(WA), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .refresh_req(refresh_a),
        .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_rs(rs_a), .cmd_data(data_a),
        .char_addr(addr_a), .char_data(cdata_a), .init_done(init_a), .frame_done(fd_a));
    lcd_frame_sequencer #(.POWERUP_CYCLES(PB), .CLEAR_CYCLES(CB), .REFRESH_CYCLES(RB),
        .NUM_LINES(LB), .CHARS_PER_LINE(WB), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .refresh_req(refresh_b),
        .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_rs(rs_b), .cmd_data(data_b),
        .char_addr(addr_b), .char_data(cdata_b), .init_done(init_b), .frame_done(fd_b));
    always @(posedge clk) begin
        cdata_a <= mem_a[addr_a];
        cdata_b <= mem_b[addr_b];
    end
    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, ncyc);
        end
    endtask
    function automatic logic [7:0] ddram_cmd(input int l);
        return 8'h80 | (l == 1 ? 8'h40 : l == 2 ? 8'h14 : l == 3 ? 8'h54 : 8'h00);
    endfunction
    task automatic push(input int d, input logic rs, input logic [7:0] data, input int t);
        item_t it;
        it.rs = rs;
        it.data = data;
        it.t = t;
        if (d == 0) qa.push_back(it);
        else qb.push_back(it);
    endtask
    task automatic push_frame(input int d, input int t);
        int lines = d == 0 ? LA : LB;
        int w = d == 0 ? WA : WB;
        int tt = t;
        for (int l = 0; l < lines; l++) begin
            push(d, 1'b0, ddram_cmd(l), tt);
            for (int c = 0; c < w; c++) begin
                if (tt >= 0) tt += 2;
                if (d == 0) push(d, 1'b1, mem_a[l*w+c], tt);
                else push(d, 1'b1, mem_b[l*w+c], tt);
            end
            if (tt >= 0) tt += 1;
        end
        if (d == 0) fqa.push_back(tt);
        else fqb.push_back(tt);
    endtask
    task automatic push_init(input int d, input int t);
        int cw = d == 0 ? CA : CB;
        push(d, 1'b0, 8'h38, t);
        push(d, 1'b0, 8'h06, t < 0 ? -1 : t + 1);
        push(d, 1'b0, 8'h0C, t < 0 ? -1 : t + 2);
        push(d, 1'b0, 8'h01, t < 0 ? -1 : t + 3);
        push_frame(d, t < 0 ? -1 : t + 4 + cw);
    endtask
    task automatic sb(input int d, input logic rs, input logic [7:0] data);
        item_t it;
        string p = d == 0 ? "a" : "b";
        if (d == 0 ? qa.size() == 0 : qb.size() == 0) begin
            check({p, "_unexpected_cmd_data"}, data, -1);
            return;
        end
        if (d == 0) it = qa.pop_front();
        else it = qb.pop_front();
        check({p, "_cmd_rs"}, rs, it.rs);
        check({p, "_cmd_data"}, data, it.data);
        if (it.t >= 0) check({p, "_cmd_cycle"}, ncyc, it.t);
    endtask
    task automatic fd_check(input int d, input logic fdv);
        int t;
        string p = d == 0 ? "a" : "b";
        if (d == 0 ? fqa.size() == 0 : fqb.size() == 0) begin
            check({p, "_unexpected_frame_done"}, fdv, 0);
            return;
        end
        if (d == 0) t = fqa.pop_front();
        else t = fqb.pop_front();
        if (t >= 0) check({p, "_frame_done_cycle"}, ncyc, t);
    endtask
    task automatic wait_fd(input int d, output int m);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(d == 0 ? fd_a : fd_b) && k < 3000);
        check(d == 0 ? "a_frame_done_seen" : "b_frame_done_seen", d == 0 ? fd_a : fd_b, 1);
        m = ncyc;
    endtask
    initial begin
        logic hold_a = 1'b0;
        logic hrs_a = 1'b0;
        logic [7:0] hdata_a = '0;
        forever begin
            @(negedge clk);
            if (reset_a) begin
                if (hold_a) begin
                    check("a_hold_valid", valid_a, 1);
                    check("a_hold_rs", rs_a, hrs_a);
                    check("a_hold_data", data_a, hdata_a);
                end
                if (valid_a && ready_a) sb(0, rs_a, data_a);
                if (fd_a) fd_check(0, fd_a);
            end
            hold_a = reset_a && valid_a && !ready_a;
            hrs_a = rs_a;
            hdata_a = data_a;
            if (reset_b) begin
                if (valid_b && ready_b) sb(1, rs_b, data_b);
                if (fd_b) fd_check(1, fd_b);
                if (int'(addr_b) > max_b) max_b = int'(addr_b);
                if (prev_addr_b == LB*WB-1 && addr_b == 0) wrap_b = 1'b1;
                prev_addr_b = int'(addr_b);
            end
            ncyc++;
        end
    end
    initial forever begin
        @(posedge clk); #2;
        if (mode_a == 0) ready_a = 1'b1;
        else if (mode_a == 1) ready_a = 1'b0;
        else if (stall > 0) begin
            ready_a = 1'b0;
            stall--;
        end else if ($urandom_range(0, 2) == 0) begin
            ready_a = 1'b0;
            stall = $urandom_range(0, 6);
        end else ready_a = 1'b1;
    end
    initial begin
        int n, m, k;
        for (int i = 0; i < LA*WA; i++) mem_a[i] = 8'($urandom_range(32, 126));
        for (int i = 0; i < LB*WB; i++) mem_b[i] = 8'($urandom_range(32, 126));
        #1 reset_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_valid", valid_a, 0);
        check("a_reset_rs", rs_a, 0);
        check("a_reset_data", data_a, 0);
        check("a_reset_addr", addr_a, 0);
        check("a_reset_init_done", init_a, 0);
        check("a_reset_frame_done", fd_a, 0);
        reset_a = 1'b1;
        @(posedge clk); #1;
        enable_a = 1'b1;
        n = ncyc;
        push_init(0, n + PA + 1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!init_a && k < 200);
        check("a_init_done_cycle", ncyc, n + PA + 1 + 4 + CA);
        wait_fd(0, m);
        push_frame(0, m + RA);
        wait_fd(0, m);
        push_frame(0, m + 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        refresh_a = 1'b1;
        @(posedge clk); #1;
        refresh_a = 1'b0;
        wait_fd(0, m);
        enable_a = 1'b0;
        repeat (RA + 10) @(posedge clk);
        #1;
        check("a_idle_valid", valid_a, 0);
        check("a_idle_init_done_kept", init_a, 1);
        enable_a = 1'b1;
        n = ncyc;
        push_frame(0, n + 1);
        wait_fd(0, m);
        push_frame(0, -1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(valid_a && rs_a) && k < 200);
        mode_a = 1;
        check("a_reached_write_char", valid_a && rs_a, 1);
        repeat (3) @(posedge clk);
        #3 reset_a = 1'b0;
        #1;
        check("a_async_reset_valid", valid_a, 0);
        check("a_async_reset_rs", rs_a, 0);
        check("a_async_reset_data", data_a, 0);
        check("a_async_reset_addr", addr_a, 0);
        check("a_async_reset_init_done", init_a, 0);
        check("a_async_reset_frame_done", fd_a, 0);
        qa.delete();
        fqa.delete();
        enable_a = 1'b0;
        mode_a = 2;
        @(posedge clk); #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        enable_a = 1'b1;
        n = ncyc;
        push_init(0, -1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!valid_a && k < 200);
        check("a_reinit_first_cmd_cycle", ncyc, n + PA + 1);
        check("a_reinit_first_cmd", data_a, 8'h38);
        wait_fd(0, m);
        push_frame(0, -1);
        wait_fd(0, m);
        enable_a = 1'b0;
        mode_a = 0;
        repeat (5) @(posedge clk);
        #1;
        check("a_queue_drained", qa.size(), 0);
        check("a_frame_done_drained", fqa.size(), 0);
        k = 0;
        while (!done_b && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check("b_finished", done_b, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
    initial begin
        int n, m;
        #1 reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b_reset_valid", valid_b, 0);
        check("b_reset_addr", addr_b, 0);
        reset_b = 1'b1;
        @(posedge clk); #1;
        enable_b = 1'b1;
        n = ncyc;
        push_init(1, n + PB + 1);
        wait_fd(1, m);
        push_frame(1, m + RB);
        wait_fd(1, m);
        enable_b = 1'b0;
        check("b_queue_drained", qb.size(), 0);
        check("b_max_char_addr", max_b, LB*WB-1);
        check("b_char_addr_wrap", wrap_b, 1);
        done_b = 1'b1;
    end
endmodule
